// File: rtl/keypad_scan.sv
// Matrix keypad scanner: drives one row low at a time, debounces press and release,
// and reports the held key. Optional KEY_CODE_EN adds key_code = {key_row, key_col}.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       apt,
    output logic       key_pulse,
    output logic [1:0] key_row,
    output logic [1:0] key_col,
`ifdef KEY_CODE_EN
    output logic [3:0] key_code,
`endif
    output logic [1:0] state_now
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN       = 2'b00,
        DB_PRESS   = 2'b01,
        HELD       = 2'b10,
        DB_RELEASE = 2'b11
    } state_t;

    state_t          state, state_d;
    logic [3:0]      col_m, col_s;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [DW-1:0]   dbcnt, dbcnt_d;
    logic [1:0]      cand_row, cand_row_d, cand_col, cand_col_d;
    logic [1:0]      key_row_d, key_col_d, row_idx, low_col;
    logic [3:0]      row_d, row_rot;
    logic            apt_d, pulse_d, cand_hit, key_hit, db_done, any_low;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_m <= 4'b1111;
            col_s <= 4'b1111;
            presc <= '0;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
            presc <= (presc == PW'(SCAN_DIV - 1)) ? '0 : presc + 1'b1;
        end
    end

    assign tick     = (presc == PW'(SCAN_DIV - 1));
    assign row_rot  = {row_out[2:0], row_out[3]};
    assign any_low  = (col_s != 4'b1111);
    assign cand_hit = ~col_s[cand_col];
    assign key_hit  = ~col_s[key_col];
    assign db_done  = (dbcnt >= DW'(DEBOUNCE_CNT));
    assign state_now = state;

    always_comb begin
        case (row_out)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        // Lowest-numbered closed column wins when several are low.
        if (!col_s[0])      low_col = 2'd0;
        else if (!col_s[1]) low_col = 2'd1;
        else if (!col_s[2]) low_col = 2'd2;
        else                low_col = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (tick) begin
            case (state)
                SCAN:       if (any_low) state_d = DB_PRESS;
                DB_PRESS:   state_d = cand_hit ? (db_done ? HELD : DB_PRESS) : SCAN;
                HELD:       if (!key_hit) state_d = DB_RELEASE;
                DB_RELEASE: state_d = !key_hit ? (db_done ? SCAN : DB_RELEASE) : HELD;
                default:    state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        row_d      = row_out;
        apt_d      = apt;
        pulse_d    = 1'b0;
        key_row_d  = key_row;
        key_col_d  = key_col;
        cand_row_d = cand_row;
        cand_col_d = cand_col;
        dbcnt_d    = dbcnt;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        cand_row_d = row_idx;
                        cand_col_d = low_col;
                        dbcnt_d    = DW'(1);
                    end else begin
                        row_d = row_rot;
                    end
                end
                DB_PRESS: begin
                    if (cand_hit) begin
                        if (db_done) begin
                            key_row_d = cand_row;
                            key_col_d = cand_col;
                            apt_d     = 1'b1;
                            pulse_d   = 1'b1;
                            dbcnt_d   = '0;
                        end else begin
                            dbcnt_d = dbcnt + 1'b1;
                        end
                    end else begin
                        dbcnt_d = '0;
                        row_d   = row_rot;
                    end
                end
                HELD: if (!key_hit) dbcnt_d = DW'(1);
                DB_RELEASE: begin
                    if (!key_hit) begin
                        if (db_done) begin
                            apt_d   = 1'b0;
                            row_d   = row_rot;
                            dbcnt_d = '0;
                        end else begin
                            dbcnt_d = dbcnt + 1'b1;
                        end
                    end else begin
                        dbcnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_out   <= 4'b1110;
            apt       <= 1'b0;
            key_pulse <= 1'b0;
            key_row   <= '0;
            key_col   <= '0;
            cand_row  <= '0;
            cand_col  <= '0;
            dbcnt     <= '0;
        end else begin
            row_out   <= row_d;
            apt       <= apt_d;
            key_pulse <= pulse_d;
            key_row   <= key_row_d;
            key_col   <= key_col_d;
            cand_row  <= cand_row_d;
            cand_col  <= cand_col_d;
            dbcnt     <= dbcnt_d;
        end
    end

`ifdef KEY_CODE_EN
    always_ff @(posedge clk) begin
        if (rst) key_code <= '0;
        else     key_code <= {key_row_d, key_col_d};
    end
`endif
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3: a keypad model drives col_in
// from the pressed-key matrix; accepted keys are checked against an expected queue.
module tb_keypad_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       apt, key_pulse;
    logic [1:0] key_row, key_col, state_now;
`ifdef KEY_CODE_EN
    logic [3:0] key_code;
`endif

    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c closed
    logic [3:0]  exp_q[$];
    int          cmp_cnt = 0;
    int          fail_cnt = 0;
    int          pulse_cnt = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .apt(apt),
        .key_pulse(key_pulse), .key_row(key_row), .key_col(key_col),
`ifdef KEY_CODE_EN
        .key_code(key_code),
`endif
        .state_now(state_now)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
    end

    // Monitor: every key_pulse consumes one expected key.
    always @(negedge clk) begin
        if (key_pulse === 1'b1) begin
            pulse_cnt++;
            cmp_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_pulse: got key %0d/%0d, required no pulse", key_row, key_col);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if ({key_row, key_col} !== e) begin
                    fail_cnt++;
                    $display("FAIL pulse_key: got %h required %h", {key_row, key_col}, e);
                end
`ifdef KEY_CODE_EN
                cmp_cnt++;
                if (key_code !== e) begin
                    fail_cnt++;
                    $display("FAIL key_code: got %h required %h", key_code, e);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] s, input int bound, output int n);
        n = 0;
        while (state_now !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (state_now !== s) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL %s: timeout, state %0d required %0d", name, state_now, s);
        end
    endtask

    task automatic wait_apt(input string name, input logic v, input int bound, output int n);
        n = 0;
        while (apt !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (apt !== v) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL %s: timeout, apt %0b required %0b", name, apt, v);
        end
    endtask

    task automatic wait_row_change(input int bound, output int n);
        logic [3:0] prev;
        prev = row_out;
        n = 0;
        while (row_out === prev && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, p0;
        logic [3:0] seq [4];
        seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;

        // Reset and idle scanning
        repeat (3) @(negedge clk);
        check("rst_row", row_out, 4'b1110);
        check("rst_apt", apt, 0);
        check("rst_state", state_now, 0);
        check("rst_pulse", key_pulse, 0);
        check("rst_key", {key_row, key_col}, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_row_change(20, n);
            check("idle_period", n, 4);
            check("idle_row", row_out, seq[i]);
        end
        check("idle_apt", apt, 0);

        // Press row2/col1 and hold
        p0 = pulse_cnt;
        exp_q.push_back(4'h9);
        pressed[9] = 1'b1;
        wait_state("press_detect", 2'd1, 40, n);
        wait_apt("press_accept", 1'b1, 40, n);
        check("press_latency", n, 12);
        check("press_row", key_row, 2);
        check("press_col", key_col, 1);
        check("press_state", state_now, 2);
        check("press_rowout", row_out, 4'b1011);
        repeat (40) @(negedge clk);
        check("held_rowout", row_out, 4'b1011);
        check("held_apt", apt, 1);
        check("held_pulses", pulse_cnt - p0, 1);

        // Release
        pressed = '0;
        wait_state("release_detect", 2'd3, 20, n);
        wait_apt("release_accept", 1'b0, 40, n);
        check("release_latency", n, 12);
        check("release_state", state_now, 0);
        check("release_rowout", row_out, 4'b0111);
        check("release_key", {key_row, key_col}, 4'h9);

        // Press bounce on row0/col0
        p0 = pulse_cnt;
        pressed[0] = 1'b1;
        wait_state("pbounce_detect", 2'd1, 40, n);
        pressed = '0;
        wait_state("pbounce_back", 2'd0, 8, n);
        check("pbounce_rowout", row_out, 4'b1101);
        check("pbounce_apt", apt, 0);
        repeat (20) @(negedge clk);
        check("pbounce_pulses", pulse_cnt - p0, 0);

        // Release bounce on row1/col3
        p0 = pulse_cnt;
        exp_q.push_back(4'h7);
        pressed[7] = 1'b1;
        wait_apt("rbounce_accept", 1'b1, 100, n);
        pressed = '0;
        wait_state("rbounce_detect", 2'd3, 20, n);
        pressed[7] = 1'b1;
        wait_state("rbounce_back", 2'd2, 8, n);
        check("rbounce_apt", apt, 1);
        repeat (10) @(negedge clk);
        check("rbounce_pulses", pulse_cnt - p0, 1);
        pressed = '0;
        wait_apt("rbounce_release", 1'b0, 60, n);

        // Two columns on row0, then a second key while held
        p0 = pulse_cnt;
        exp_q.push_back(4'h1);
        pressed[1] = 1'b1;
        pressed[3] = 1'b1;
        wait_apt("multi_accept", 1'b1, 100, n);
        check("multi_col", key_col, 1);
        check("multi_row", key_row, 0);
        pressed[12] = 1'b1;
        repeat (40) @(negedge clk);
        check("rollover_state", state_now, 2);
        check("rollover_key", {key_row, key_col}, 4'h1);
        check("rollover_pulses", pulse_cnt - p0, 1);
        pressed = '0;
        wait_apt("multi_release", 1'b0, 60, n);

        // Reset while held, key re-detected afterwards
        exp_q.push_back(4'hE);
        pressed[14] = 1'b1;
        wait_apt("rst_hold_accept", 1'b1, 100, n);
`ifdef KEY_CODE_EN
        check("key_code_E", key_code, 4'hE);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("midrst_apt", apt, 0);
        check("midrst_row", row_out, 4'b1110);
        check("midrst_state", state_now, 0);
        check("midrst_key", {key_row, key_col}, 0);
        exp_q.push_back(4'hE);
        rst = 1'b0;
        wait_apt("redetect_accept", 1'b1, 200, n);
        check("redetect_key", {key_row, key_col}, 4'hE);
        pressed = '0;
        wait_apt("redetect_release", 1'b0, 60, n);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
